// File: rtl/bcd_timer_alarm.sv
// MM:SS BCD countdown/count-up timer with editable preset, run/pause control,
// optional auto-reload and a timed or acknowledged expiry alarm.
module bcd_timer_alarm #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned MIN_MAX     = 59,
    parameter bit          AUTO_RELOAD = 1'b0,
    parameter int unsigned ALARM_LEN   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic        start,
    input  logic        load,
    input  logic        inc_sec,
    input  logic        dec_sec,
    input  logic        inc_min,
    input  logic        dec_min,
    input  logic        ack,
    output logic [15:0] digits,
    output logic        running,
    output logic        expired,
    output logic        alarm,
    output logic [1:0]  dbg_state_o
);

    localparam int          TW          = $clog2(TICK_DIV);
    localparam int          AW          = (ALARM_LEN > 1) ? $clog2(ALARM_LEN + 1) : 1;
    localparam int unsigned ALARM_LAST  = (ALARM_LEN > 0) ? ALARM_LEN - 1 : 0;
    localparam bit          ALARM_TIMED = (ALARM_LEN != 0);
    localparam logic [7:0]  MIN_MAX_BCD = 8'(((MIN_MAX / 10) * 16) + (MIN_MAX % 10));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t          state_q;
    logic            mode_q;
    logic [15:0]     preset_q;
    logic [15:0]     count_q;
    logic [TW-1:0]   tick_q;
    logic [AW-1:0]   alarm_cnt_q;
    logic [15:0]     digits_q;
    logic            running_q;
    logic            expired_q;
    logic            alarm_q;

    logic [15:0]     count_inc, count_dec, count_tick_d;
    logic [15:0]     terminal, init_val, load_init;
    logic [15:0]     preset_d;
    logic            tick;
    logic [TW-1:0]   tick_d;

    // Two-digit BCD step; high digit wraps at hi_max, so each nibble stays legal.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] hi_max);
        if (v[3:0] != 4'd9)       return {v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != hi_max) return {v[7:4] + 4'd1, 4'd0};
        else                       return 8'h00;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [3:0] hi_max);
        if (v[3:0] != 4'd0)      return {v[7:4], v[3:0] - 4'd1};
        else if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                     return {hi_max, 4'd9};
    endfunction

    always_comb begin
        count_inc    = {(count_q[7:0] == 8'h59) ? bcd_inc(count_q[15:8], 4'd9) : count_q[15:8],
                        bcd_inc(count_q[7:0], 4'd5)};
        count_dec    = {(count_q[7:0] == 8'h00) ? bcd_dec(count_q[15:8], 4'd9) : count_q[15:8],
                        bcd_dec(count_q[7:0], 4'd5)};
        count_tick_d = mode_q ? count_inc : count_dec;
        terminal     = mode_q ? preset_q : 16'h0000;
        init_val     = mode_q ? 16'h0000 : preset_q;
        load_init    = mode ? 16'h0000 : preset_q;
        tick         = (tick_q == TW'(TICK_DIV - 1));
        tick_d       = tick ? '0 : tick_q + 1'b1;

        // Seconds never carry into minutes while editing; minutes wrap at MIN_MAX.
        preset_d = preset_q;
        if (inc_sec && !dec_sec) preset_d[7:0] = bcd_inc(preset_q[7:0], 4'd5);
        if (dec_sec && !inc_sec) preset_d[7:0] = bcd_dec(preset_q[7:0], 4'd5);
        if (inc_min && !dec_min)
            preset_d[15:8] = (preset_q[15:8] == MIN_MAX_BCD) ? 8'h00 : bcd_inc(preset_q[15:8], 4'd9);
        if (dec_min && !inc_min)
            preset_d[15:8] = (preset_q[15:8] == 8'h00) ? MIN_MAX_BCD : bcd_dec(preset_q[15:8], 4'd9);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            preset_q    <= '0;
            count_q     <= '0;
            tick_q      <= '0;
            alarm_cnt_q <= '0;
            digits_q    <= '0;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            digits_q  <= (state_q == IDLE) ? preset_q : count_q;
            running_q <= (state_q == RUN);

            if (state_q == IDLE || state_q == PAUSE) preset_q <= preset_d;

            if (load) begin
                alarm_q <= 1'b0;
                count_q <= load_init;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && preset_q != 16'h0000) begin
                            mode_q  <= mode;
                            count_q <= mode ? 16'h0000 : preset_q;
                            tick_q  <= '0;
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (ack) alarm_q <= 1'b0;
                        if (start) begin
                            state_q <= PAUSE;
                        end else begin
                            tick_q <= tick_d;
                            if (tick) begin
                                if (count_tick_d == terminal) begin
                                    expired_q   <= 1'b1;
                                    alarm_q     <= 1'b1;
                                    alarm_cnt_q <= '0;
                                    if (AUTO_RELOAD) begin
                                        count_q <= init_val;
                                    end else begin
                                        count_q <= count_tick_d;
                                        state_q <= ALARM;
                                    end
                                end else begin
                                    count_q <= count_tick_d;
                                    // Auto-reload alarm times out while the count keeps running.
                                    if (alarm_q && !ack && ALARM_TIMED) begin
                                        if (alarm_cnt_q == AW'(ALARM_LAST)) alarm_q <= 1'b0;
                                        else alarm_cnt_q <= alarm_cnt_q + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    PAUSE: begin
                        if (ack) alarm_q <= 1'b0;
                        if (start) state_q <= RUN;
                    end
                    ALARM: begin
                        if (ack) begin
                            alarm_q <= 1'b0;
                            count_q <= init_val;
                            state_q <= IDLE;
                        end else begin
                            tick_q <= tick_d;
                            if (tick && ALARM_TIMED) begin
                                if (alarm_cnt_q == AW'(ALARM_LAST)) begin
                                    alarm_q <= 1'b0;
                                    count_q <= init_val;
                                    state_q <= IDLE;
                                end else begin
                                    alarm_cnt_q <= alarm_cnt_q + 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign digits      = digits_q;
    assign running     = running_q;
    assign expired     = expired_q;
    assign alarm       = alarm_q;
    assign dbg_state_o = state_q;

endmodule
